// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready parallel-to-serial shifter with a per-word bit period.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module sim_reg #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);
  always_ff @(posedge clk)
    if (rst) o_dout <= RESET_VAL;
    else if (i_wen) o_dout <= i_din;
endmodule

module mux_key_with_default #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic [KEY_LEN-1:0]                    i_key,
  input  logic [DATA_LEN-1:0]                   i_default,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  i_lut,
  output logic [DATA_LEN-1:0]                   o_out
);
  localparam int PAIR = KEY_LEN + DATA_LEN;
  always_comb begin
    o_out = i_default;
    for (int k = 0; k < NR_KEY; k++)
      if (i_lut[k*PAIR+DATA_LEN +: KEY_LEN] == i_key) o_out = i_lut[k*PAIR +: DATA_LEN];
  end
endmodule

module bit_serializer #(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [DIV_W-1:0]  div,
  input  logic              idle_level,
  output logic              bit_out,
  output logic              bit_strobe,
  output logic              busy
);
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int IDX_W = $clog2(DATA_W + 2);
  localparam logic [2:0] SEL_HOLD = 3'd0, SEL_IDLE = 3'd1, SEL_LOAD = 3'd2, SEL_NEXT = 3'd3, SEL_PAR = 3'd4;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t r_state, w_state_nxt;
  logic [DATA_W-1:0] r_sh, w_sh_nxt, w_sh_shift;
  logic [DIV_W-1:0]  r_div, w_div_nxt, r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt, w_idx_inc;
  logic [2:0]        w_sel;
  logic r_bit, w_bit_nxt, r_strobe, w_strobe_nxt, r_busy, w_busy_nxt;
  logic w_par, w_xfer, w_wrap, w_last, w_head_in, w_head_sh;
  // The shift register keeps the bit currently on the line at its head end.
  assign w_sh_shift = (LSB_FIRST != 0) ? (r_sh >> 1) : (r_sh << 1);
  assign w_head_in  = (LSB_FIRST != 0) ? data_in[0] : data_in[DATA_W-1];
  assign w_head_sh  = (LSB_FIRST != 0) ? w_sh_shift[0] : w_sh_shift[DATA_W-1];
  assign w_idx_inc  = r_idx + IDX_W'(1);
  assign w_wrap     = r_cnt == r_div;
  assign w_last     = (r_state == SHIFT) && w_wrap && (r_idx == IDX_W'(NBITS - 1));
  assign data_ready = !reset && ((r_state == IDLE) || w_last);
  assign w_xfer     = data_valid && data_ready;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic r_par;
  sim_reg #(.WIDTH(1)) u_par (.clk(clk), .rst(reset), .i_wen(w_xfer), .i_din(^data_in), .o_dout(r_par));
  assign w_par = r_par;
`else
  assign w_par = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt  = r_state;
    w_sh_nxt     = r_sh;
    w_div_nxt    = r_div;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_sel        = SEL_HOLD;
    w_strobe_nxt = 1'b0;
    w_busy_nxt   = r_busy;
    if (w_xfer) begin
      w_state_nxt  = SHIFT;
      w_sh_nxt     = data_in;
      w_div_nxt    = div;
      w_cnt_nxt    = '0;
      w_idx_nxt    = '0;
      w_sel        = SEL_LOAD;
      w_strobe_nxt = 1'b1;
      w_busy_nxt   = 1'b1;
    end else if (r_state == IDLE || w_last) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_sel       = SEL_IDLE;
      w_busy_nxt  = 1'b0;
    end else if (w_wrap) begin
      w_cnt_nxt    = '0;
      w_idx_nxt    = w_idx_inc;
      w_sh_nxt     = w_sh_shift;
      w_sel        = (w_idx_inc == IDX_W'(DATA_W)) ? SEL_PAR : SEL_NEXT;
      w_strobe_nxt = 1'b1;
    end else begin
      w_cnt_nxt = r_cnt + DIV_W'(1);
    end
  end
  mux_key_with_default #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(1)) u_bit_mux (
    .i_key(w_sel),
    .i_default(r_bit),
    .i_lut({SEL_PAR, w_par, SEL_NEXT, w_head_sh, SEL_LOAD, w_head_in, SEL_IDLE, idle_level}),
    .o_out(w_bit_nxt)
  );
  sim_reg #(.WIDTH(DATA_W)) u_sh  (.clk(clk), .rst(reset), .i_wen(1'b1), .i_din(w_sh_nxt), .o_dout(r_sh));
  sim_reg #(.WIDTH(DIV_W))  u_div (.clk(clk), .rst(reset), .i_wen(1'b1), .i_din(w_div_nxt), .o_dout(r_div));
  sim_reg #(.WIDTH(DIV_W))  u_cnt (.clk(clk), .rst(reset), .i_wen(1'b1), .i_din(w_cnt_nxt), .o_dout(r_cnt));
  sim_reg #(.WIDTH(IDX_W))  u_idx (.clk(clk), .rst(reset), .i_wen(1'b1), .i_din(w_idx_nxt), .o_dout(r_idx));
  sim_reg #(.WIDTH(1)) u_bit    (.clk(clk), .rst(reset), .i_wen(1'b1), .i_din(w_bit_nxt), .o_dout(r_bit));
  sim_reg #(.WIDTH(1)) u_strobe (.clk(clk), .rst(reset), .i_wen(1'b1), .i_din(w_strobe_nxt), .o_dout(r_strobe));
  sim_reg #(.WIDTH(1)) u_busy   (.clk(clk), .rst(reset), .i_wen(1'b1), .i_din(w_busy_nxt), .o_dout(r_busy));
  assign bit_out    = r_bit;
  assign bit_strobe = r_strobe;
  assign busy       = r_busy;
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed and random words checked cycle by cycle against a queue of expected line cycles.
module tb_bit_serializer;
  localparam int DW = 8, VW = 8, LSB = 0;
  logic clk = 1'b0;
  logic reset, data_valid, idle_level, data_ready, bit_out, bit_strobe, busy;
  logic [DW-1:0] data_in;
  logic [VW-1:0] div;
  int checks = 0, failures = 0;
  logic [1:0] q[$];
  logic m_line;
  logic a;
  always #5 clk = ~clk;
  bit_serializer #(.DATA_W(DW), .DIV_W(VW), .LSB_FIRST(LSB)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .div(div), .idle_level(idle_level), .bit_out(bit_out), .bit_strobe(bit_strobe), .busy(busy)
  );
  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask
  // Each queue entry is one expected line cycle: {bit, strobe}.
  task automatic push_word(input logic [DW-1:0] d, input logic [VW-1:0] dv);
    logic [DW:0] bits;
    int n;
    n = DW;
    bits = '0;
    for (int i = 0; i < DW; i++) bits[i] = (LSB != 0) ? d[i] : d[DW-1-i];
`ifdef BIT_SERIALIZER_PARITY_EN
    bits[DW] = ^d;
    n = DW + 1;
`endif
    for (int i = 0; i < n; i++)
      for (int c = 0; c <= int'(dv); c++) q.push_back({bits[i], c == 0});
  endtask
  task automatic cyc(input logic r, input logic v, input logic [DW-1:0] d, input logic [VW-1:0] dv,
                     input logic il, output logic acc);
    @(negedge clk);
    reset = r; data_valid = v; data_in = d; div = dv; idle_level = il;
    #1;
    if (q.size() > 0) begin
      chk("bit", bit_out, q[0][1]);
      chk("strobe", bit_strobe, q[0][0]);
      chk("busy", busy, 1'b1);
    end else begin
      chk("idle_bit", bit_out, m_line);
      chk("idle_strobe", bit_strobe, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end
    chk("ready", data_ready, !r && q.size() <= 1);
    acc = !r && v && q.size() <= 1;
    if (r) q.delete();
    else begin
      if (q.size() > 0) void'(q.pop_front());
      if (acc) push_word(d, dv);
    end
    if (q.size() == 0) m_line = r ? 1'b0 : il;
  endtask
  initial begin
    reset = 1'b1; data_valid = 1'b0; data_in = '0; div = '0; idle_level = 1'b0; m_line = 1'b0;
    repeat (2) @(posedge clk);
    cyc(1, 0, 8'h00, 0, 0, a);
    cyc(0, 1, 8'hF0, 0, 0, a);
    chk("accept_f0", a, 1'b1);
    repeat (10) cyc(0, 0, 8'h00, 0, 0, a);
    cyc(0, 1, 8'hA5, 0, 0, a);
    a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(0, 1, 8'h3C, 0, 0, a);
      if (a) break;
    end
    chk("b2b_accept", a, 1'b1);
    repeat (10) cyc(0, 0, 8'h00, 0, 0, a);
    cyc(0, 1, 8'h81, 2, 0, a);
    repeat (30) cyc(0, 0, 8'h55, 0, 1, a);
    cyc(0, 1, 8'hFF, 0, 0, a);
    repeat (3) cyc(0, 0, 8'h00, 0, 0, a);
    cyc(1, 1, 8'hFF, 0, 0, a);
    chk("reset_blocks_accept", a, 1'b0);
    repeat (10) cyc(0, 0, 8'h00, 0, 0, a);
    repeat (10) cyc(0, 0, 8'h00, 0, 1, a);
    repeat (400)
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, 8'($urandom),
          8'($urandom_range(0, 3)), 1'($urandom), a);
    repeat (40) cyc(0, 0, 8'h00, 0, 1, a);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial stage directly upstream of the serial sequence-detector FSM.
- Accepts DATA_W-bit words on a valid/ready handshake and shifts them out one bit per bit period on bit_out.
- bit_out feeds the detector's serial input. With div=0 each clock cycle carries one new bit, matching the detector's one-bit-per-clock sampling.
- Built from the team's register (SimReg) and key-mux (MuxKeyWithDefault) primitives plus plain counters.

Parameters:
- DATA_W, 8, word width in bits (2..32).
- DIV_W, 8, width of the bit-period divider input.
- LSB_FIRST, 0, 1 = bit 0 shifted first; 0 = bit DATA_W-1 shifted first.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_W  word to serialize.
- data_valid  input  1  data_in valid.
- data_ready  output  1  block can accept a word this cycle.
- div  input  DIV_W  bit period = div+1 clock cycles; sampled only at word acceptance.
- idle_level  input  1  line level driven while idle.
- bit_out  output  1  serial data, registered.
- bit_strobe  output  1  high on the first cycle of each bit period, registered.
- busy  output  1  high while a word is being shifted, registered.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, bit_out=0, bit_strobe=0, busy=0, shift register=0, counters=0. data_ready is forced 0 while reset=1.
- States: IDLE and SHIFT.
- Transfer: occurs when data_valid && data_ready on a rising edge.
- data_ready (combinational from state and counters):
  - 1 in IDLE.
  - 1 in SHIFT only on the last cycle of the last bit period (back-to-back support).
  - 0 otherwise.
- IDLE:
  - bit_out <= idle_level every cycle; bit_strobe=0; busy=0.
  - On transfer: load shift register with data_in, latch div into period register, bit index <= 0, go to SHIFT.
- SHIFT:
  - The first bit appears on bit_out the cycle after transfer, with bit_strobe=1 and busy=1 (latency 1).
  - Each bit is held exactly div_latched+1 cycles. The period counter runs 0..div_latched.
  - At wrap-around, the next bit is presented and bit_strobe pulses for one cycle.
  - Bit order follows LSB_FIRST.
  - After DATA_W bits (DATA_W+1 with the optional feature), the block is at the last cycle of the last period:
    - Transfer in that cycle: reload and continue SHIFT. The next word's first bit follows with no idle gap; the new div takes effect for it.
    - No transfer: go to IDLE. Next cycle bit_out=idle_level, busy=0.
- Mid-word changes: changes on div, idle_level or data_in while in SHIFT have no effect on the current word.
- div=0: one bit per cycle, and bit_strobe is high every SHIFT cycle.
- Reset mid-word: the word is discarded with no resume. Outputs take reset values on the next edge.
- Simultaneous reset and data_valid: reset wins; the word is not accepted.
- Counter widths:
  - Bit index: clog2(DATA_W+2) bits.
  - Period counter: DIV_W bits. No overflow, since it compares against div_latched before incrementing.

Optional Feature:
- Macro: BIT_SERIALIZER_PARITY_EN.
- Defined: after the DATA_W data bits, one extra bit is shifted with its own full period and strobe. The bit is even parity, the XOR of all data bits of the word. data_ready's early assertion moves to the last cycle of the parity bit.
- Undefined: exactly DATA_W bits per word, no parity logic synthesized.

Test Plan:
- Reset, div=0, LSB_FIRST=0, send 0xF0 -> bit_out 1,1,1,1,0,0,0,0 on cycles 1..8 after accept. bit_strobe=1 on cycles 1..8; data_ready=0 cycles 1..7, 1 on cycle 8; busy falls cycle 9.
- data_valid held, 0xA5 then 0x3C, div=0 -> 16 contiguous bits 1010010100111100, no idle cycle, 16 strobes, exactly two transfers.
- div=2, send 0x81, change div to 0 after accept -> each bit held 3 cycles (24 cycles total), strobe every 3rd cycle, pattern 1,0,0,0,0,0,0,1.
- Reset asserted one cycle during the 4th bit of 0xFF -> next cycle bit_out=0, busy=0, strobe=0. After reset release data_ready=1, and no remaining bits of 0xFF ever appear.
- idle_level=1, no valid for 10 cycles -> bit_out=1, strobe=0. Then LSB_FIRST=1 build, send 0x01 -> 1,0,0,0,0,0,0,0.
- BIT_SERIALIZER_PARITY_EN defined, div=0, send 0x07 -> 8 data bits then 9th bit=1 with strobe. Send 0x03 -> 9th bit=0. data_ready high on the 9th bit cycle only.
